mtr_drv_pwm: RTL and testbench
==============================

// Module: mtr_drv_pwm
// PURPOSE
//   Motor-drive PWM backend that consumes the PID speed outputs: converts signed
//   11-bit lft_spd/rght_spd into complementary, dead-time-protected H-bridge gate
//   pairs. One 2048-clock PWM period is shared by both motors. New duty values
//   are latched only at the period boundary, so no mid-period glitches occur.
// PARAMETERS
//   DEAD_TIME  32   non-overlap clocks inserted before each gate rises (1..255)
// PORTS
//   clk          in   1   system clock; single clock domain
//   rst          in   1   asynchronous, active-high reset
//   lft_spd      in   11  signed two's-complement left speed (-1024..+1023)
//   rght_spd     in   11  signed two's-complement right speed
//   lftPWM1      out  1   left high-side gate (forward drive)
//   lftPWM2      out  1   left low-side gate, complementary to lftPWM1
//   rghtPWM1     out  1   right high-side gate
//   rghtPWM2     out  1   right low-side gate
//   period_strt  out  1   1-clock pulse on the first clock of each PWM period
// BEHAVIOUR
//   - Reset (async, rst=1): cnt=0, lft_duty=rght_duty=0x400, all PWM outputs=0,
//     period_strt=0. All four gates drop to 0 immediately, mid-period included.
//   - cnt: 11-bit free-running up-counter, 0..2047, wraps to 0; period = 2048 clks.
//   - Duty map: duty = spd + 0x400 mod 2048, i.e. spd with bit 10 inverted.
//     -1024 -> 0, 0 -> 0x400 (50%, motor stopped), +1023 -> 0x7FF.
//   - Duty latch: lft_duty/rght_duty load from the mapped inputs on the clock
//     where cnt==2047 and take effect from cnt==0. Input changes at any other
//     time are ignored until the next boundary.
//   - period_strt: registered; high for exactly the 1 clock after the edge on
//     which cnt wrapped to 0.
//   - Gates are registered, 1-clock latency from the cnt value:
//       PWM1 <= (cnt >= DEAD_TIME) && (cnt < duty)
//       PWM2 <= ({1'b0,cnt} >= {1'b0,duty} + DEAD_TIME)   // 12-bit compare, no wrap
//   - Dead time: PWM1 and PWM2 of the same motor are never both 1. Each rising
//     edge follows the other gate's falling edge by >= DEAD_TIME clocks, and
//     this holds across the period wrap.
//   - Boundaries: duty <= DEAD_TIME -> PWM1 stays 0 all period.
//     duty + DEAD_TIME > 2047 -> PWM2 stays 0 all period.
//     duty=0 -> PWM2 high for cnt DEAD_TIME..2047.
//   - Left and right channels are independent except for the shared cnt.
//   - No handshake: inputs are sampled levels. Upstream holds spd at 0 when not
//     moving, which yields 50/50 complementary drive (active brake).
// TESTING
//   1. DEAD_TIME=32, lft_spd=0 held -> lftPWM1 high 992 clks (cnt 32..1023),
//      lftPWM2 high 992 clks (cnt 1056..2047); period_strt every 2048 clks.
//   2. rght_spd=+1023 (0x3FF) -> rghtPWM1 high 2015 clks per period,
//      rghtPWM2 never high.
//   3. lft_spd=-1024 (0x400) -> lftPWM1 never high, lftPWM2 high 2016 clks
//      (cnt 32..2047).
//   4. Change lft_spd 0 -> +256 at cnt=500 -> current period still shows
//      PWM1 = 992 clks; next period shows 1248 clks (cnt 32..1279).
//   5. Assert rst at cnt=700 -> all gates 0 in the same cycle. Release -> cnt
//      restarts at 0 with 50% duty; first PWM1 rise 33 clks after release.
//   6. Random spd every period, 10k periods -> assertion: never PWM1&PWM2 on
//      the same motor; every PWM1/PWM2 high-to-low/low-to-high gap >= 32 clks.

Source files
------------

// File: rtl/mtr_drv_pwm_if.sv
// rtl/mtr_drv_pwm_if.sv - speed inputs and gate outputs of the motor PWM backend
//   lft_spd/rght_spd : signed 11-bit speed levels from the PID stage
//   lftPWM1/lftPWM2  : left high/low-side gates
//   rghtPWM1/rghtPWM2: right high/low-side gates
//   period_strt      : 1-clock pulse at the first clock of each PWM period
interface mtr_drv_pwm_if;
  logic signed [10:0] lft_spd;
  logic signed [10:0] rght_spd;
  logic               lftPWM1;
  logic               lftPWM2;
  logic               rghtPWM1;
  logic               rghtPWM2;
  logic               period_strt;

  modport master (
    output lft_spd, rght_spd,
    input  lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, period_strt
  );

  modport slave (
    input  lft_spd, rght_spd,
    output lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, period_strt
  );
endinterface

// File: rtl/mtr_drv_pwm.sv
// rtl/mtr_drv_pwm.sv - dead-time-protected complementary H-bridge PWM for two motors
//   clk : system clock
//   rst : asynchronous active-high reset, forces all gates low at once
//   bus : speed levels in, gate pairs and period_strt out
module mtr_drv_pwm #(
  parameter int DEAD_TIME = 32
) (
  input  logic         clk,
  input  logic         rst,
  mtr_drv_pwm_if.slave bus
);

  localparam logic [10:0] DT11 = 11'(DEAD_TIME);
  localparam logic [11:0] DT12 = 12'(DEAD_TIME);

  logic [10:0] cnt_q, cnt_d;
  logic [10:0] lft_duty_q, lft_duty_d;
  logic [10:0] rght_duty_q, rght_duty_d;
  logic        period_strt_q, period_strt_d;
  logic        lft_pwm1_q, lft_pwm1_d;
  logic        lft_pwm2_q, lft_pwm2_d;
  logic        rght_pwm1_q, rght_pwm1_d;
  logic        rght_pwm2_q, rght_pwm2_d;
  logic        boundary;

  // Offset-binary: adding 0x400 mod 2048 is the same as flipping the sign bit.
  function automatic logic [10:0] spd_to_duty(input logic [10:0] spd);
    return {~spd[10], spd[9:0]};
  endfunction

  always_comb begin
    cnt_d         = cnt_q + 11'd1;
    boundary      = (cnt_q == 11'h7FF);
    lft_duty_d    = lft_duty_q;
    rght_duty_d   = rght_duty_q;
    // Duty only changes on the last clock so a period never mixes two values.
    if (boundary) begin
      lft_duty_d  = spd_to_duty(bus.lft_spd);
      rght_duty_d = spd_to_duty(bus.rght_spd);
    end
    period_strt_d = boundary;

    // High side waits DEAD_TIME after the wrap, where the low side just fell.
    lft_pwm1_d  = (cnt_q >= DT11) && (cnt_q < lft_duty_q);
    rght_pwm1_d = (cnt_q >= DT11) && (cnt_q < rght_duty_q);
    // 12-bit sum so duty+DEAD_TIME beyond 2047 disables the low side rather than wrapping.
    lft_pwm2_d  = ({1'b0, cnt_q} >= ({1'b0, lft_duty_q} + DT12));
    rght_pwm2_d = ({1'b0, cnt_q} >= ({1'b0, rght_duty_q} + DT12));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= 11'd0;
      lft_duty_q    <= 11'h400;
      rght_duty_q   <= 11'h400;
      period_strt_q <= 1'b0;
      lft_pwm1_q    <= 1'b0;
      lft_pwm2_q    <= 1'b0;
      rght_pwm1_q   <= 1'b0;
      rght_pwm2_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      lft_duty_q    <= lft_duty_d;
      rght_duty_q   <= rght_duty_d;
      period_strt_q <= period_strt_d;
      lft_pwm1_q    <= lft_pwm1_d;
      lft_pwm2_q    <= lft_pwm2_d;
      rght_pwm1_q   <= rght_pwm1_d;
      rght_pwm2_q   <= rght_pwm2_d;
    end
  end

  assign bus.lftPWM1     = lft_pwm1_q;
  assign bus.lftPWM2     = lft_pwm2_q;
  assign bus.rghtPWM1    = rght_pwm1_q;
  assign bus.rghtPWM2    = rght_pwm2_q;
  assign bus.period_strt = period_strt_q;

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// tb/tb_mtr_drv_pwm.sv - scoreboard bench for mtr_drv_pwm
module tb_mtr_drv_pwm;

  localparam int DT = 32;
  localparam int NTAB = 7;
  localparam int NRND = 12;

  typedef struct {
    int l1;
    int l2;
    int r1;
    int r2;
  } exp_t;

  logic clk;
  logic rst;
  mtr_drv_pwm_if bus ();

  mtr_drv_pwm #(.DEAD_TIME(DT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  // Hand-computed high-clock counts per period for each speed pair.
  int tl [NTAB] = '{0, 256, -1024, 991, -992, -1000, -1};
  int tr [NTAB] = '{1023, -1024, 0, 992, -991, 1000, 1};
  int el1[NTAB] = '{992, 1248, 0, 1983, 0, 0, 991};
  int el2[NTAB] = '{992, 736, 2016, 1, 1984, 1992, 993};
  int er1[NTAB] = '{2015, 0, 992, 1984, 1, 1992, 993};
  int er2[NTAB] = '{0, 2016, 992, 0, 1983, 0, 991};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int hi1(input int spd);
    int duty;
    duty = (spd + 1024) & 2047;
    return (duty > DT) ? duty - DT : 0;
  endfunction

  function automatic int hi2(input int spd);
    int duty;
    duty = (spd + 1024) & 2047;
    return (duty + DT <= 2047) ? 2048 - duty - DT : 0;
  endfunction

  // Monitor: counts gate-high clocks per period window and checks dead time.
  // A window closes on the period_strt sample, which still carries the last
  // count value of the previous period because the gates lag cnt by one clock.
  int  cyc = 0;
  bit  started = 0;
  int  c_l1, c_l2, c_r1, c_r2, lviol, rviol;
  logic p_l1, p_l2, p_r1, p_r2;
  int  lf_l1, lf_l2, lf_r1, lf_r2;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      started = 0;
      c_l1 = 0; c_l2 = 0; c_r1 = 0; c_r2 = 0; lviol = 0; rviol = 0;
      p_l1 = 0; p_l2 = 0; p_r1 = 0; p_r2 = 0;
      lf_l1 = -100000; lf_l2 = -100000; lf_r1 = -100000; lf_r2 = -100000;
    end else begin
      c_l1 += int'(bus.lftPWM1);
      c_l2 += int'(bus.lftPWM2);
      c_r1 += int'(bus.rghtPWM1);
      c_r2 += int'(bus.rghtPWM2);
      if (bus.lftPWM1 && bus.lftPWM2) lviol++;
      if (bus.rghtPWM1 && bus.rghtPWM2) rviol++;
      if (bus.lftPWM1 && !p_l1 && (cyc - lf_l2 < DT)) lviol++;
      if (bus.lftPWM2 && !p_l2 && (cyc - lf_l1 < DT)) lviol++;
      if (bus.rghtPWM1 && !p_r1 && (cyc - lf_r2 < DT)) rviol++;
      if (bus.rghtPWM2 && !p_r2 && (cyc - lf_r1 < DT)) rviol++;
      if (!bus.lftPWM1 && p_l1) lf_l1 = cyc;
      if (!bus.lftPWM2 && p_l2) lf_l2 = cyc;
      if (!bus.rghtPWM1 && p_r1) lf_r1 = cyc;
      if (!bus.rghtPWM2 && p_r2) lf_r2 = cyc;
      p_l1 = bus.lftPWM1; p_l2 = bus.lftPWM2;
      p_r1 = bus.rghtPWM1; p_r2 = bus.rghtPWM2;
      if (bus.period_strt) begin
        if (started) begin
          if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("lft_pwm1_hi", c_l1, e.l1);
            check("lft_pwm2_hi", c_l2, e.l2);
            check("rght_pwm1_hi", c_r1, e.r1);
            check("rght_pwm2_hi", c_r2, e.r2);
            check("lft_deadtime_viol", lviol, 0);
            check("rght_deadtime_viol", rviol, 0);
          end
        end
        started = 1;
        c_l1 = 0; c_l2 = 0; c_r1 = 0; c_r2 = 0; lviol = 0; rviol = 0;
      end
    end
  end

  task automatic wait_pstrt();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.period_strt && n < 3000);
    if (!bus.period_strt) check("period_strt_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    exp_t e;
    int l, r, n;
    rst = 1'b1;
    bus.lft_spd  = 11'(tl[0]);
    bus.rght_spd = 11'(tr[0]);
    @(negedge clk);
    @(negedge clk);
    check("rst_gates", int'({bus.lftPWM1, bus.lftPWM2, bus.rghtPWM1, bus.rghtPWM2}), 0);
    check("rst_period_strt", int'(bus.period_strt), 0);

    e = '{el1[0], el2[0], er1[0], er2[0]};
    exp_q.push_back(e);
    rst = 1'b0;

    // Each new speed is applied mid-period (cnt ~500) and must only show up
    // in the following period.
    for (int i = 1; i < NTAB + NRND; i++) begin
      wait_pstrt();
      repeat (500) @(negedge clk);
      if (i < NTAB) begin
        l = tl[i];
        r = tr[i];
        e = '{el1[i], el2[i], er1[i], er2[i]};
      end else begin
        l = int'($urandom_range(0, 2047)) - 1024;
        r = int'($urandom_range(0, 2047)) - 1024;
        e = '{hi1(l), hi2(l), hi1(r), hi2(r)};
      end
      bus.lft_spd  = 11'(l);
      bus.rght_spd = 11'(r);
      exp_q.push_back(e);
    end
    wait_drain();

    // Mid-period asynchronous reset, then restart from cnt=0 at 50% duty.
    bus.lft_spd  = 11'(0);
    bus.rght_spd = 11'(0);
    repeat (700) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_gates", int'({bus.lftPWM1, bus.lftPWM2, bus.rghtPWM1, bus.rghtPWM2}), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!bus.lftPWM1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("first_pwm1_rise", n, 33);
    while (!bus.period_strt && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("first_period_strt", n, 2048);
    e = '{992, 992, 992, 992};
    exp_q.push_back(e);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
